// File: rtl/rec_fn_to_in_pipe.sv
// rec_fn_to_in_pipe: recFN (sign, EXP_W+1 exp, SIG_W-1 fract) to integer,
// 3 stages (decode, align, round/saturate) with valid/ready and bubble collapse.
// Ports: clock, reset (async, active-high); io_in_valid/ready, io_in_bits_in,
// io_in_bits_signedOut, io_in_bits_roundingMode; io_out_valid/ready,
// io_out_bits_out, io_out_bits_flags {invalid, overflow, inexact}.
// Macro RECFN_TO_IN_STICKY_EN adds io_flagsSticky and io_flagsClear.
module rec_fn_to_in_pipe #(
    parameter int INT_W = 64,
    parameter int EXP_W = 8,
    parameter int SIG_W = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [EXP_W+SIG_W:0] io_in_bits_in,
    input  logic                 io_in_bits_signedOut,
    input  logic [2:0]           io_in_bits_roundingMode,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [INT_W-1:0]     io_out_bits_out,
`ifdef RECFN_TO_IN_STICKY_EN
    output logic [2:0]           io_flagsSticky,
    input  logic                 io_flagsClear,
`endif
    output logic [2:0]           io_out_bits_flags
);
    localparam int EW  = EXP_W + 2;
    localparam int FW  = INT_W + SIG_W;
    localparam int SHW = $clog2(INT_W + 1);
    localparam logic [INT_W+1:0] HALF = (INT_W+2)'(1) << (INT_W - 1);

    logic s1Valid, s2Valid;
    logic s1Load, s2Load, s3Load;

    assign s3Load      = ~io_out_valid | io_out_ready;
    assign s2Load      = ~s2Valid | s3Load;
    assign s1Load      = ~s1Valid | s2Load;
    assign io_in_ready = s1Load;

    // Stage 1: decode
    logic             inSign;
    logic [EXP_W:0]   inExp;
    logic [SIG_W-2:0] inFract;
    logic [2:0]       inCls;

    assign inSign  = io_in_bits_in[EXP_W+SIG_W];
    assign inExp   = io_in_bits_in[EXP_W+SIG_W-1 -: EXP_W+1];
    assign inFract = io_in_bits_in[SIG_W-2:0];
    assign inCls   = inExp[EXP_W -: 3];

    logic                 s1Sign, s1Zero, s1NaN, s1Inf, s1Signed;
    logic signed [EW-1:0] s1Exp;
    logic [SIG_W-2:0]     s1Fract;
    logic [2:0]           s1Rm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1Valid  <= 1'b0;
            s1Sign   <= 1'b0;
            s1Zero   <= 1'b0;
            s1NaN    <= 1'b0;
            s1Inf    <= 1'b0;
            s1Signed <= 1'b0;
            s1Exp    <= '0;
            s1Fract  <= '0;
            s1Rm     <= '0;
        end else begin
            if (s1Load) s1Valid <= io_in_valid;
            if (s1Load & io_in_valid) begin
                s1Sign   <= inSign;
                s1Zero   <= (inCls == 3'b000);
                s1NaN    <= (inCls == 3'b111);
                s1Inf    <= (inCls == 3'b110);
                s1Signed <= io_in_bits_signedOut;
                s1Exp    <= $signed({1'b0, inExp}) - $signed(EW'(2 ** EXP_W));
                s1Fract  <= inFract;
                s1Rm     <= io_in_bits_roundingMode;
            end
        end
    end

    // Stage 2: align. Integer part sits above bit SIG_W-1 of the field.
    // Shift clamps at INT_W: anything that large is out of range anyway.
    logic [EW-2:0]  expMag;
    logic [SHW-1:0] shamt;
    logic [FW-1:0]  field;
    logic [INT_W:0] alMag;
    logic           alGuard, alSticky;

    assign expMag = s1Exp[EW-2:0];

    always_comb begin
        shamt    = '0;
        field    = '0;
        alMag    = '0;
        alGuard  = 1'b0;
        alSticky = 1'b0;
        if (~(s1Zero | s1NaN | s1Inf)) begin
            if (s1Exp[EW-1]) begin
                // magnitude below 1: only exp -1 puts the hidden bit in guard
                alGuard  = (s1Exp == '1);
                alSticky = (s1Exp == '1) ? |s1Fract : 1'b1;
            end else begin
                shamt    = (expMag > (EW-1)'(INT_W)) ? SHW'(INT_W)
                                                     : expMag[SHW-1:0];
                field    = FW'({1'b1, s1Fract}) << shamt;
                alMag    = field[FW-1:SIG_W-1];
                alGuard  = field[SIG_W-2];
                alSticky = |field[SIG_W-3:0];
            end
        end
    end

    logic           s2Sign, s2NaN, s2Inf, s2Signed, s2Guard, s2Sticky;
    logic [2:0]     s2Rm;
    logic [INT_W:0] s2Mag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2Valid  <= 1'b0;
            s2Sign   <= 1'b0;
            s2NaN    <= 1'b0;
            s2Inf    <= 1'b0;
            s2Signed <= 1'b0;
            s2Guard  <= 1'b0;
            s2Sticky <= 1'b0;
            s2Rm     <= '0;
            s2Mag    <= '0;
        end else begin
            if (s2Load) s2Valid <= s1Valid;
            if (s2Load & s1Valid) begin
                s2Sign   <= s1Sign;
                s2NaN    <= s1NaN;
                s2Inf    <= s1Inf;
                s2Signed <= s1Signed;
                s2Guard  <= alGuard;
                s2Sticky <= alSticky;
                s2Rm     <= s1Rm;
                s2Mag    <= alMag;
            end
        end
    end

    // Stage 3: round, range check, saturate
    logic             rInexact, rInc, rBad, rInvalid, rPosSat;
    logic [INT_W+1:0] rounded;
    logic [INT_W-1:0] rSat, rValue, rOut;
    logic [2:0]       rFlags;

    always_comb begin
        rInexact = s2Guard | s2Sticky;
        case (s2Rm)
            3'd0:    rInc = s2Guard & (s2Sticky | s2Mag[0]);
            3'd2:    rInc = s2Sign & rInexact;
            3'd3:    rInc = ~s2Sign & rInexact;
            3'd4:    rInc = s2Guard;
            default: rInc = 1'b0;
        endcase
        rounded = {1'b0, s2Mag} + (INT_W+2)'(rInc);
        if (s2Rm == 3'd6) rounded[0] = rounded[0] | rInexact;
        if (s2Signed) rBad = s2Sign ? (rounded > HALF) : (rounded >= HALF);
        else          rBad = s2Sign ? (rounded != '0)
                                    : (rounded[INT_W+1:INT_W] != 2'b00);
        rInvalid = s2NaN | s2Inf | rBad;
        rPosSat  = s2NaN | ~s2Sign;
        if (s2Signed) rSat = rPosSat ? {1'b0, {(INT_W-1){1'b1}}}
                                     : {1'b1, {(INT_W-1){1'b0}}};
        else          rSat = rPosSat ? '1 : '0;
        rValue = s2Sign ? -rounded[INT_W-1:0] : rounded[INT_W-1:0];
        rOut   = rInvalid ? rSat : rValue;
        rFlags = rInvalid ? 3'b100 : {2'b00, rInexact};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_valid      <= 1'b0;
            io_out_bits_out   <= '0;
            io_out_bits_flags <= '0;
        end else begin
            if (s3Load) io_out_valid <= s2Valid;
            if (s3Load & s2Valid) begin
                io_out_bits_out   <= rOut;
                io_out_bits_flags <= rFlags;
            end
        end
    end

`ifdef RECFN_TO_IN_STICKY_EN
    logic outFire;

    assign outFire = io_out_valid & io_out_ready;

    // a beat handed off in the same cycle as a clear survives the clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              io_flagsSticky <= '0;
        else if (outFire)       io_flagsSticky <= io_flagsClear ? io_out_bits_flags
                                         : (io_flagsSticky | io_out_bits_flags);
        else if (io_flagsClear) io_flagsSticky <= '0;
    end
`endif

endmodule

// File: tb/tb_rec_fn_to_in_pipe.sv
// tb_rec_fn_to_in_pipe: directed bench for rec_fn_to_in_pipe (INT_W 64 and 32).
// Each scenario task checks its own results against hand-computed values.
module tb_rec_fn_to_in_pipe;
    logic        clock, reset;
    logic        inValid, inReady, inReady32;
    logic [32:0] inBits;
    logic        inSigned;
    logic [2:0]  inRm;
    logic        outValid, outValid32, outReady;
    logic [63:0] outBits;
    logic [31:0] outBits32;
    logic [2:0]  outFlags, outFlags32;
`ifdef RECFN_TO_IN_STICKY_EN
    logic [2:0]  sticky, sticky32;
`endif
    logic        flagsClear;

    int nChecks = 0;
    int nFails  = 0;

    rec_fn_to_in_pipe #(.INT_W(64)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(inValid), .io_in_ready(inReady),
        .io_in_bits_in(inBits), .io_in_bits_signedOut(inSigned),
        .io_in_bits_roundingMode(inRm),
        .io_out_valid(outValid), .io_out_ready(outReady),
        .io_out_bits_out(outBits),
`ifdef RECFN_TO_IN_STICKY_EN
        .io_flagsSticky(sticky), .io_flagsClear(flagsClear),
`endif
        .io_out_bits_flags(outFlags)
    );

    rec_fn_to_in_pipe #(.INT_W(32)) dut32 (
        .clock(clock), .reset(reset),
        .io_in_valid(inValid), .io_in_ready(inReady32),
        .io_in_bits_in(inBits), .io_in_bits_signedOut(inSigned),
        .io_in_bits_roundingMode(inRm),
        .io_out_valid(outValid32), .io_out_ready(outReady),
        .io_out_bits_out(outBits32),
`ifdef RECFN_TO_IN_STICKY_EN
        .io_flagsSticky(sticky32), .io_flagsClear(flagsClear),
`endif
        .io_out_bits_flags(outFlags32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one beat with io_out_ready high; returns outputs at first valid
    // and the cycle count from the accept cycle (lat = -1 on timeout).
    task automatic run_beat(input logic [32:0] v, input logic sg,
                            input logic [2:0] rm,
                            output logic [63:0] r, output logic [2:0] f,
                            output logic [31:0] r32, output logic [2:0] f32,
                            output int lat);
        int n;
        inValid = 1'b1; inBits = v; inSigned = sg; inRm = rm;
        outReady = 1'b1;
        n = 0;
        #1;
        while (!inReady && n < 20) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        inValid = 1'b0;
        lat = 1;
        while (!outValid && lat < 12) begin
            @(posedge clock); #1; lat++;
        end
        if (outValid) begin
            r = outBits; f = outFlags; r32 = outBits32; f32 = outFlags32;
        end else begin
            r = 'x; f = 'x; r32 = 'x; f32 = 'x; lat = -1;
        end
    endtask

    task automatic test_reset();
        nChecks++;
        if (outValid !== 1'b0) begin
            nFails++; $display("FAIL reset_valid: got %b want 0", outValid);
        end
        nChecks++;
        if (outBits !== 64'h0) begin
            nFails++; $display("FAIL reset_out: got %h want 0", outBits);
        end
        nChecks++;
        if (outFlags !== 3'b000) begin
            nFails++; $display("FAIL reset_flags: got %b want 000", outFlags);
        end
        nChecks++;
        if (inReady !== 1'b1) begin
            nFails++; $display("FAIL reset_ready: got %b want 1", inReady);
        end
        nChecks++;
        if (outBits32 !== 32'h0) begin
            nFails++; $display("FAIL reset_out32: got %h want 0", outBits32);
        end
`ifdef RECFN_TO_IN_STICKY_EN
        nChecks++;
        if (sticky !== 3'b000) begin
            nFails++; $display("FAIL reset_sticky: got %b want 000", sticky);
        end
`endif
    endtask

    task automatic test_one();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        run_beat(33'h080000000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h1) begin
            nFails++; $display("FAIL one_out: got %h want 1", r);
        end
        nChecks++;
        if (f !== 3'b000) begin
            nFails++; $display("FAIL one_flags: got %b want 000", f);
        end
        nChecks++;
        if (lat !== 3) begin
            nFails++; $display("FAIL one_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_neg_rounding();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        logic [2:0]  rms  [7];
        logic [63:0] want [7];
        logic [31:0] want32;
        rms  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        want = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE,
                 64'hFFFF_FFFF_FFFF_FFFD};
        for (int i = 0; i < 7; i++) begin
            run_beat(33'h180A00000, 1'b1, rms[i], r, f, r32, f32, lat);
            want32 = want[i][31:0];
            nChecks++;
            if (r !== want[i]) begin
                nFails++;
                $display("FAIL neg2p5_rm%0d_out: got %h want %h", rms[i], r, want[i]);
            end
            nChecks++;
            if (f !== 3'b001) begin
                nFails++;
                $display("FAIL neg2p5_rm%0d_flags: got %b want 001", rms[i], f);
            end
            nChecks++;
            if (r32 !== want32) begin
                nFails++;
                $display("FAIL neg2p5_rm%0d_out32: got %h want %h", rms[i], r32, want32);
            end
        end
    endtask

    task automatic test_nan();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        run_beat(33'h0E0400000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            nFails++; $display("FAIL nan_signed_out: got %h want 7fff..", r);
        end
        nChecks++;
        if (f !== 3'b100) begin
            nFails++; $display("FAIL nan_signed_flags: got %b want 100", f);
        end
        nChecks++;
        if (r32 !== 32'h7FFF_FFFF) begin
            nFails++; $display("FAIL nan_signed_out32: got %h want 7fffffff", r32);
        end
        run_beat(33'h0E0400000, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            nFails++; $display("FAIL nan_unsigned_out: got %h want ffff..", r);
        end
        nChecks++;
        if (f !== 3'b100) begin
            nFails++; $display("FAIL nan_unsigned_flags: got %b want 100", f);
        end
    endtask

    task automatic test_unsigned();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        run_beat(33'h180000000, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h0 || f !== 3'b100) begin
            nFails++; $display("FAIL uns_neg1: got %h/%b want 0/100", r, f);
        end
        // -0.3 rounds to zero: inexact only
        run_beat(33'h17F19999A, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h0 || f !== 3'b001) begin
            nFails++; $display("FAIL uns_neg0p3_rne: got %h/%b want 0/001", r, f);
        end
        // -0.3 rounded down becomes -1: invalid
        run_beat(33'h17F19999A, 1'b0, 3'd2, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h0 || f !== 3'b100) begin
            nFails++; $display("FAIL uns_neg0p3_rdn: got %h/%b want 0/100", r, f);
        end
        run_beat(33'h180A00000, 1'b0, 3'd1, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h0 || f !== 3'b100) begin
            nFails++; $display("FAIL uns_neg2p5: got %h/%b want 0/100", r, f);
        end
        // 2^63 fits unsigned 64
        run_beat(33'h09F800000, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h8000_0000_0000_0000 || f !== 3'b000) begin
            nFails++; $display("FAIL uns_2p63: got %h/%b want 8000../000", r, f);
        end
    endtask

    task automatic test_int32();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        run_beat(33'h08F800000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r32 !== 32'h7FFF_FFFF || f32 !== 3'b100) begin
            nFails++; $display("FAIL i32_2p31_signed: got %h/%b want 7fffffff/100", r32, f32);
        end
        nChecks++;
        if (r !== 64'h8000_0000 || f !== 3'b000) begin
            nFails++; $display("FAIL i64_2p31_signed: got %h/%b want 80000000/000", r, f);
        end
        run_beat(33'h18F800000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r32 !== 32'h8000_0000 || f32 !== 3'b000) begin
            nFails++; $display("FAIL i32_neg2p31_signed: got %h/%b want 80000000/000", r32, f32);
        end
        run_beat(33'h08F800000, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r32 !== 32'h8000_0000 || f32 !== 3'b000) begin
            nFails++; $display("FAIL i32_2p31_unsigned: got %h/%b want 80000000/000", r32, f32);
        end
        run_beat(33'h090000000, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r32 !== 32'hFFFF_FFFF || f32 !== 3'b100) begin
            nFails++; $display("FAIL i32_2p32_unsigned: got %h/%b want ffffffff/100", r32, f32);
        end
    endtask

    task automatic test_boundaries();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        run_beat(33'h000000000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h0 || f !== 3'b000) begin
            nFails++; $display("FAIL zero: got %h/%b want 0/000", r, f);
        end
        run_beat(33'h07F800000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h0 || f !== 3'b001) begin
            nFails++; $display("FAIL half_rne: got %h/%b want 0/001", r, f);
        end
        run_beat(33'h07F800000, 1'b1, 3'd4, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h1 || f !== 3'b001) begin
            nFails++; $display("FAIL half_rmm: got %h/%b want 1/001", r, f);
        end
        run_beat(33'h080400000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h2 || f !== 3'b001) begin
            nFails++; $display("FAIL 1p5_rne: got %h/%b want 2/001", r, f);
        end
        run_beat(33'h1C0000000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h8000_0000_0000_0000 || f !== 3'b100) begin
            nFails++; $display("FAIL neg_inf: got %h/%b want 8000../100", r, f);
        end
        run_beat(33'h0A0000000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h7FFF_FFFF_FFFF_FFFF || f !== 3'b100) begin
            nFails++; $display("FAIL 2p64_signed: got %h/%b want 7fff../100", r, f);
        end
        run_beat(33'h0A0000000, 1'b0, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || f !== 3'b100) begin
            nFails++; $display("FAIL 2p64_unsigned: got %h/%b want ffff../100", r, f);
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] vals [6];
        int          acc, got;
        logic        rdy;
        logic [63:0] held;
        vals = '{33'h080000000, 33'h080800000, 33'h080C00000,
                 33'h081000000, 33'h081200000, 33'h081400000};
        acc = 0; got = 0;
        @(posedge clock); #1;
        outReady = 1'b0; inSigned = 1'b1; inRm = 3'd0;
        for (int c = 0; c < 8; c++) begin
            inValid = 1'b1; inBits = vals[acc < 6 ? acc : 5];
            #1 rdy = inReady;
            @(posedge clock); #1;
            if (rdy) acc++;
        end
        nChecks++;
        if (acc !== 3) begin
            nFails++; $display("FAIL bp_accepted: got %0d want 3", acc);
        end
        nChecks++;
        if (inReady !== 1'b0) begin
            nFails++; $display("FAIL bp_in_ready: got %b want 0", inReady);
        end
        nChecks++;
        if (outValid !== 1'b1 || outBits !== 64'h1) begin
            nFails++; $display("FAIL bp_head: got %b/%h want 1/1", outValid, outBits);
        end
        held = outBits;
        repeat (3) begin
            @(posedge clock); #1;
        end
        nChecks++;
        if (outValid !== 1'b1 || outBits !== held) begin
            nFails++; $display("FAIL bp_stable: got %b/%h want 1/%h", outValid, outBits, held);
        end
        fork
            begin
                for (int c = 0; c < 40 && acc < 6; c++) begin
                    inValid = 1'b1; inBits = vals[acc];
                    #1 rdy = inReady;
                    @(posedge clock); #1;
                    if (rdy) acc++;
                end
                inValid = 1'b0;
            end
            begin
                outReady = 1'b1;
                for (int c = 0; c < 40 && got < 6; c++) begin
                    #1;
                    if (outValid) begin
                        nChecks++;
                        if (outBits !== 64'(got + 1)) begin
                            nFails++;
                            $display("FAIL bp_order%0d: got %h want %0d", got, outBits, got + 1);
                        end
                        got++;
                    end
                    @(posedge clock); #1;
                end
            end
        join
        nChecks++;
        if (got !== 6 || acc !== 6) begin
            nFails++; $display("FAIL bp_count: got %0d out/%0d in want 6/6", got, acc);
        end
        repeat (3) begin
            @(posedge clock); #1;
        end
        nChecks++;
        if (outValid !== 1'b0) begin
            nFails++; $display("FAIL bp_no_dup: got valid %b want 0", outValid);
        end
    endtask

`ifdef RECFN_TO_IN_STICKY_EN
    task automatic test_sticky();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat;
        flagsClear = 1'b1;
        @(posedge clock); #1;
        flagsClear = 1'b0;
        nChecks++;
        if (sticky !== 3'b000) begin
            nFails++; $display("FAIL sticky_clear0: got %b want 000", sticky);
        end
        run_beat(33'h180A00000, 1'b1, 3'd0, r, f, r32, f32, lat);
        @(posedge clock); #1;
        run_beat(33'h0E0400000, 1'b1, 3'd0, r, f, r32, f32, lat);
        @(posedge clock); #1;
        nChecks++;
        if (sticky !== 3'b101) begin
            nFails++; $display("FAIL sticky_accum: got %b want 101", sticky);
        end
        flagsClear = 1'b1;
        @(posedge clock); #1;
        flagsClear = 1'b0;
        nChecks++;
        if (sticky !== 3'b000) begin
            nFails++; $display("FAIL sticky_clear: got %b want 000", sticky);
        end
        run_beat(33'h0E0400000, 1'b1, 3'd0, r, f, r32, f32, lat);
        run_beat(33'h180A00000, 1'b1, 3'd0, r, f, r32, f32, lat);
        flagsClear = 1'b1;
        @(posedge clock); #1;
        flagsClear = 1'b0;
        nChecks++;
        if (sticky !== 3'b001) begin
            nFails++; $display("FAIL sticky_set_wins: got %b want 001", sticky);
        end
    endtask
`endif

    task automatic test_reset_midstream();
        logic [63:0] r; logic [2:0] f; logic [31:0] r32; logic [2:0] f32;
        int lat, n;
        run_beat(33'h0E0400000, 1'b1, 3'd0, r, f, r32, f32, lat);
        @(posedge clock); #1;
        outReady = 1'b0; inSigned = 1'b1; inRm = 3'd0;
        inValid = 1'b1; inBits = 33'h080000000;
        @(posedge clock); #1;
        inBits = 33'h080800000;
        @(posedge clock); #1;
        inValid = 1'b0;
        n = 0;
        while (!outValid && n < 10) begin
            @(posedge clock); #1; n++;
        end
        nChecks++;
        if (outValid !== 1'b1) begin
            nFails++; $display("FAIL mid_prefill: got valid %b want 1", outValid);
        end
        #2 reset = 1'b1;
        #1;
        nChecks++;
        if (outValid !== 1'b0 || outBits !== 64'h0 || outFlags !== 3'b000) begin
            nFails++;
            $display("FAIL mid_reset: got %b/%h/%b want 0/0/000", outValid, outBits, outFlags);
        end
`ifdef RECFN_TO_IN_STICKY_EN
        nChecks++;
        if (sticky !== 3'b000) begin
            nFails++; $display("FAIL mid_reset_sticky: got %b want 000", sticky);
        end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        run_beat(33'h080000000, 1'b1, 3'd0, r, f, r32, f32, lat);
        nChecks++;
        if (r !== 64'h1 || lat !== 3) begin
            nFails++; $display("FAIL mid_after: got %h lat %0d want 1 lat 3", r, lat);
        end
    endtask

    initial begin
        reset = 1'b1; inValid = 1'b0; inBits = '0; inSigned = 1'b0;
        inRm = 3'd0; outReady = 1'b0; flagsClear = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        test_reset();
        test_one();
        test_neg_rounding();
        test_nan();
        test_unsigned();
        test_int32();
        test_boundaries();
        test_backpressure();
`ifdef RECFN_TO_IN_STICKY_EN
        test_sticky();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
